game_ctrl: RTL and testbench
============================

GAME_CTRL -- requirements
Module: game_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000, is the number of consecutive stable iCLK cycles required to accept a change on iSTEP.
REQ-002 Parameter CURSOR_BASE, default 70, is the pixel coordinate of cell index 0.
REQ-003 Parameter CURSOR_STEP, default 160, is the pixel pitch between adjacent cells.
REQ-004 iCLK  in  1  system clock (CLOCK_50 domain).
REQ-005 iRST  in  1  synchronous, active-high reset.
REQ-006 iSTEP  in  1  raw pushbutton, asynchronous, active-low (pressed = 0).
REQ-007 iMOVE  in  4  direction request sampled at step: [0] right, [1] left, [2] down, [3] up.
REQ-008 iPLACE  in  1  place-mark request sampled at step.
REQ-009 oCursor_X  out  10  cursor pixel X = CURSOR_BASE + CURSOR_STEP*col.
REQ-010 oCursor_Y  out  10  cursor pixel Y = CURSOR_BASE + CURSOR_STEP*row.
REQ-011 oBoard  out  18  cell k = 3*row+col at [2k+1:2k]; 00 empty, 01 X, 10 O, 11 never driven.
REQ-012 oPlayer  out  2  player to move: 01 X, 10 O.
REQ-013 oWinner  out  2  00 none/draw, 01 X won, 10 O won.
REQ-014 oGame_Over  out  1  high in WIN or DRAW state.

Function
REQ-015 iSTEP SHALL pass through a 2-flop synchronizer, then a debouncer updating its stable value only after DEBOUNCE_CYCLES identical consecutive samples.
REQ-016 A 1->0 transition of the debounced value SHALL produce a one-cycle step pulse; holding the button SHALL produce no further pulses.
REQ-017 FSM states SHALL be PLAY, CHECK, WIN, DRAW.
REQ-018 In PLAY, on step pulse (cycle t): col += 1 if iMOVE[0] & ~iMOVE[1] & col<2; col -= 1 if iMOVE[1] & ~iMOVE[0] & col>0; row likewise with [2]/[3]; opposite bits both set give no move on that axis; no wrap-around.
REQ-019 Placement in the same step SHALL target the post-move cell.
REQ-020 If iPLACE=1 and the target cell is empty, the cell SHALL be written with oPlayer at end of cycle t and state SHALL go to CHECK; occupied cell: no write, no turn change, stay PLAY.
REQ-021 CHECK (cycle t+1) SHALL evaluate the 3 rows, 3 columns, 2 diagonals of the updated board: any line all equal to oPlayer -> WIN, oWinner=oPlayer; else all 9 cells non-empty -> DRAW; else toggle oPlayer, -> PLAY; results visible from cycle t+2.
REQ-022 Step pulses arriving in CHECK SHALL be ignored.
REQ-023 In WIN or DRAW, a step pulse SHALL clear oBoard, set oWinner=00, oPlayer=01, col=row=0, -> PLAY; iMOVE/iPLACE ignored for that step.
REQ-024 oCursor_X/Y SHALL be registered, updated in the same edge as col/row.

Reset
REQ-025 On iRST=1 at a clock edge: state PLAY, col=row=0 (oCursor_X=oCursor_Y=CURSOR_BASE), oBoard=0, oPlayer=01, oWinner=00, oGame_Over=0, debouncer stable value 1, counter 0, step pulse 0.
REQ-026 iRST SHALL take priority over any simultaneous step pulse, including mid-CHECK.

Structure
REQ-027 Cell codes (EMPTY, MARK_X, MARK_O) and FSM state encodings SHALL live in shared package ttt_pkg, also used by board.
REQ-028 Synchronizer+debouncer+edge detector SHALL be sub-module key_debounce (parameter DEBOUNCE_CYCLES, ports iCLK, iRST, iKEY_N, oPRESS).

Verification (DEBOUNCE_CYCLES=4)
REQ-029 iSTEP low 3 cycles then high -> no pulse; low 10 cycles -> exactly one pulse, col unchanged if iMOVE=0.
REQ-030 From reset, steps with iMOVE=0001 x3 -> oCursor_X 230, 390, 390 (no wrap); iMOVE=0011 -> no change.
REQ-031 X places (0,0),(0,1),(0,2) interleaved with O at (1,0),(1,1) -> oWinner=01, oGame_Over=1 exactly 2 cycles after the winning step pulse; oBoard[5:0]=010101.
REQ-032 Place on occupied cell -> oBoard unchanged, oPlayer unchanged.
REQ-033 Fill board with no line complete -> DRAW, oWinner=00, oGame_Over=1; next step -> oBoard=0, oPlayer=01, oCursor=(70,70).
REQ-034 Assert iRST in the CHECK cycle -> all outputs at reset values next cycle, no toggle of oPlayer.

Source files
------------

// File: rtl/ttt_pkg.sv
// ttt_pkg: shared cell codes, FSM state encoding and line-detection helper for tic-tac-toe
// Ports: none (package).
package ttt_pkg;
    typedef enum logic [1:0] {EMPTY = 2'b00, MARK_X = 2'b01, MARK_O = 2'b10} cell_t;
    typedef enum logic [1:0] {PLAY, CHECK, WIN, DRAW} state_t;
    // m[k] flags cells owned by one player; true when any of the 8 lines is complete
    function automatic logic has_line(input logic [8:0] m);
        return (m[0] & m[1] & m[2]) | (m[3] & m[4] & m[5]) | (m[6] & m[7] & m[8]) |
               (m[0] & m[3] & m[6]) | (m[1] & m[4] & m[7]) | (m[2] & m[5] & m[8]) |
               (m[0] & m[4] & m[8]) | (m[2] & m[4] & m[6]);
    endfunction
endpackage

// File: rtl/game_ctrl_if.sv
// game_ctrl_if: button/move inputs and board/cursor status outputs of the game controller
// Ports: master drives iSTEP/iMOVE/iPLACE and observes status; slave is the controller side.
interface game_ctrl_if;
    logic        iSTEP;
    logic [3:0]  iMOVE;
    logic        iPLACE;
    logic [9:0]  oCursor_X;
    logic [9:0]  oCursor_Y;
    logic [17:0] oBoard;
    logic [1:0]  oPlayer;
    logic [1:0]  oWinner;
    logic        oGame_Over;
    modport master (output iSTEP, iMOVE, iPLACE,
                    input oCursor_X, oCursor_Y, oBoard, oPlayer, oWinner, oGame_Over);
    modport slave (input iSTEP, iMOVE, iPLACE,
                   output oCursor_X, oCursor_Y, oBoard, oPlayer, oWinner, oGame_Over);
endinterface

// File: rtl/key_debounce.sv
// key_debounce: synchronizes and debounces an active-low key, pulsing once per press
// Ports: iCLK clock, iRST sync reset, iKEY_N raw key (pressed = 0), oPRESS one-cycle press pulse.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic iCLK,
    input  logic iRST,
    input  logic iKEY_N,
    output logic oPRESS
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    logic [1:0]    sync;
    logic          stable;
    logic [CW-1:0] cnt;
    logic          settle;
    assign settle = cnt == CW'(DEBOUNCE_CYCLES - 1);
    // cnt counts consecutive samples differing from stable; the Nth one commits the change
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            sync   <= 2'b11;
            stable <= 1'b1;
            cnt    <= '0;
            oPRESS <= 1'b0;
        end else begin
            sync   <= {sync[0], iKEY_N};
            oPRESS <= 1'b0;
            if (sync[1] == stable) begin
                cnt <= '0;
            end else if (settle) begin
                cnt    <= '0;
                stable <= sync[1];
                oPRESS <= stable;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end
endmodule

// File: rtl/game_ctrl.sv
// game_ctrl: tic-tac-toe controller moving a cursor and placing marks on debounced key steps
// Ports: iCLK clock, iRST sync active-high reset, bus (slave) carrying step/move/place
//        inputs and cursor, board, player, winner and game-over outputs.
module game_ctrl
    import ttt_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CURSOR_BASE     = 70,
    parameter int CURSOR_STEP     = 160
) (
    input logic        iCLK,
    input logic        iRST,
    game_ctrl_if.slave bus
);
    state_t          state, state_nx;
    logic [8:0][1:0] board;
    cell_t           player, winner;
    logic [1:0]      col, row, col_nx, row_nx;
    logic [3:0]      idx;
    logic [8:0]      mine, filled;
    logic            press, target_free, line, full;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key (
        .iCLK  (iCLK),
        .iRST  (iRST),
        .iKEY_N(bus.iSTEP),
        .oPRESS(press)
    );

    // opposing direction bits cancel; edges saturate instead of wrapping
    always_comb begin
        col_nx = (bus.iMOVE[0] & ~bus.iMOVE[1] & (col != 2'd2)) ? col + 2'd1 :
                 (bus.iMOVE[1] & ~bus.iMOVE[0] & (col != 2'd0)) ? col - 2'd1 : col;
        row_nx = (bus.iMOVE[2] & ~bus.iMOVE[3] & (row != 2'd2)) ? row + 2'd1 :
                 (bus.iMOVE[3] & ~bus.iMOVE[2] & (row != 2'd0)) ? row - 2'd1 : row;
    end

    assign idx         = 4'(row_nx) * 4'd3 + 4'(col_nx);
    assign target_free = board[idx] == EMPTY;

    always_comb begin
        for (int k = 0; k < 9; k++) begin
            mine[k]   = board[k] == player;
            filled[k] = board[k] != EMPTY;
        end
    end

    assign line = has_line(mine);
    assign full = &filled;

    always_ff @(posedge iCLK) begin
        if (iRST) state <= PLAY;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            PLAY:    state_nx = (press && bus.iPLACE && target_free) ? CHECK : PLAY;
            CHECK:   state_nx = line ? WIN : full ? DRAW : PLAY;
            default: state_nx = press ? PLAY : state;
        endcase
    end

    always_comb begin
        bus.oGame_Over = (state == WIN) || (state == DRAW);
        bus.oBoard     = board;
        bus.oPlayer    = player;
        bus.oWinner    = winner;
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            col           <= 2'd0;
            row           <= 2'd0;
            board         <= '0;
            player        <= MARK_X;
            winner        <= EMPTY;
            bus.oCursor_X <= 10'(CURSOR_BASE);
            bus.oCursor_Y <= 10'(CURSOR_BASE);
        end else begin
            case (state)
                PLAY: begin
                    if (press) begin
                        col           <= col_nx;
                        row           <= row_nx;
                        bus.oCursor_X <= 10'(CURSOR_BASE + CURSOR_STEP * int'(col_nx));
                        bus.oCursor_Y <= 10'(CURSOR_BASE + CURSOR_STEP * int'(row_nx));
                        if (bus.iPLACE && target_free) board[idx] <= player;
                    end
                end
                CHECK: begin
                    if (line)       winner <= player;
                    else if (!full) player <= (player == MARK_X) ? MARK_O : MARK_X;
                end
                default: begin
                    if (press) begin
                        col           <= 2'd0;
                        row           <= 2'd0;
                        board         <= '0;
                        player        <= MARK_X;
                        winner        <= EMPTY;
                        bus.oCursor_X <= 10'(CURSOR_BASE);
                        bus.oCursor_Y <= 10'(CURSOR_BASE);
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_game_ctrl.sv
// tb_game_ctrl: self-checking bench comparing game_ctrl against a behavioural tic-tac-toe model
module tb_game_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    game_ctrl_if bus();
    game_ctrl #(.DEBOUNCE_CYCLES(4)) dut (.iCLK(clk), .iRST(rst), .bus(bus));

    int total = 0;
    int bad = 0;
    int m_board[9];
    int m_player, m_winner, m_over, m_col, m_row;
    int lines[8][3] = '{'{0, 1, 2}, '{3, 4, 5}, '{6, 7, 8}, '{0, 3, 6},
                        '{1, 4, 7}, '{2, 5, 8}, '{0, 4, 8}, '{2, 4, 6}};

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        foreach (m_board[k]) m_board[k] = 0;
        m_player = 1;
        m_winner = 0;
        m_over   = 0;
        m_col    = 0;
        m_row    = 0;
    endfunction

    function automatic bit model_step(input logic [3:0] mv, input bit pl);
        int k;
        bit won, full;
        if (m_over != 0) begin
            model_reset();
            return 1'b0;
        end
        if (mv[0] && !mv[1] && m_col < 2) m_col++;
        else if (mv[1] && !mv[0] && m_col > 0) m_col--;
        if (mv[2] && !mv[3] && m_row < 2) m_row++;
        else if (mv[3] && !mv[2] && m_row > 0) m_row--;
        k = 3 * m_row + m_col;
        if (!pl || m_board[k] != 0) return 1'b0;
        m_board[k] = m_player;
        won = 1'b0;
        foreach (lines[i])
            if (m_board[lines[i][0]] == m_player && m_board[lines[i][1]] == m_player &&
                m_board[lines[i][2]] == m_player) won = 1'b1;
        full = 1'b1;
        foreach (m_board[j]) if (m_board[j] == 0) full = 1'b0;
        if (won) begin
            m_winner = m_player;
            m_over   = 1;
        end else if (full) begin
            m_over = 1;
        end else begin
            m_player = 3 - m_player;
        end
        return 1'b1;
    endfunction

    function automatic int exp_board();
        int b = 0;
        foreach (m_board[k]) b |= m_board[k] << (2 * k);
        return b;
    endfunction

    task automatic check_all(input string tag);
        check({tag, ".cursor_x"}, int'(bus.oCursor_X), 70 + 160 * m_col);
        check({tag, ".cursor_y"}, int'(bus.oCursor_Y), 70 + 160 * m_row);
        check({tag, ".board"}, int'(bus.oBoard), exp_board());
        check({tag, ".player"}, int'(bus.oPlayer), m_player);
        check({tag, ".winner"}, int'(bus.oWinner), m_winner);
        check({tag, ".game_over"}, int'(bus.oGame_Over), m_over);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.iSTEP = 1'b1;
        bus.iMOVE = 4'd0;
        bus.iPLACE = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic step(input logic [3:0] mv, input bit pl);
        int n = 0;
        int held = 0;
        bit placed;
        @(negedge clk);
        bus.iMOVE = mv;
        bus.iPLACE = pl;
        bus.iSTEP = 1'b0;
        while (!dut.u_key.oPRESS && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("pulse_seen", int'(n < 20), 1);
        placed = model_step(mv, pl);
        if (n < 20) begin
            @(negedge clk);
            if (placed) check("over_at_t1", int'(bus.oGame_Over), 0);
            @(negedge clk);
            check_all("step");
            repeat (6) begin
                @(negedge clk);
                held += int'(dut.u_key.oPRESS);
            end
            check("held_no_pulse", held, 0);
        end
        bus.iSTEP = 1'b1;
        repeat (10) @(negedge clk);
        bus.iMOVE = 4'd0;
        bus.iPLACE = 1'b0;
    endtask

    task automatic place_at(input int r, input int c);
        logic [3:0] mv;
        while (m_col != c || m_row != r) begin
            mv = 4'd0;
            if (c > m_col) mv[0] = 1'b1;
            else if (c < m_col) mv[1] = 1'b1;
            if (r > m_row) mv[2] = 1'b1;
            else if (r < m_row) mv[3] = 1'b1;
            step(mv, 1'b0);
        end
        step(4'd0, 1'b1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        do_reset();
        check_all("reset");

        // 3-cycle glitch must be rejected; a long press gives exactly one step
        bus.iMOVE = 4'b0001;
        bus.iSTEP = 1'b0;
        repeat (3) @(negedge clk);
        bus.iSTEP = 1'b1;
        repeat (10) @(negedge clk);
        check("glitch_cursor_x", int'(bus.oCursor_X), 70);
        bus.iMOVE = 4'd0;
        step(4'b0000, 1'b0);
        step(4'b0001, 1'b0);
        check("right1_x", int'(bus.oCursor_X), 230);
        step(4'b0001, 1'b0);
        check("right2_x", int'(bus.oCursor_X), 390);
        step(4'b0001, 1'b0);
        check("right_sat_x", int'(bus.oCursor_X), 390);
        step(4'b0011, 1'b0);
        check("opposed_x", int'(bus.oCursor_X), 390);

        // X wins on the top row; O tries an occupied cell first
        do_reset();
        step(4'b0000, 1'b1);
        step(4'b0000, 1'b1);
        check("occupied_player", int'(bus.oPlayer), 2);
        check("occupied_board", int'(bus.oBoard), 1);
        step(4'b0100, 1'b1);
        step(4'b1001, 1'b1);
        step(4'b0100, 1'b1);
        step(4'b1001, 1'b1);
        check("win_winner", int'(bus.oWinner), 1);
        check("win_over", int'(bus.oGame_Over), 1);
        check("win_row0", int'(bus.oBoard[5:0]), 21);
        step(4'b0000, 1'b0);
        check("win_clear_board", int'(bus.oBoard), 0);

        // draw: X O X / X O O / O X X
        do_reset();
        place_at(0, 0); place_at(0, 1); place_at(0, 2); place_at(1, 1); place_at(1, 0);
        place_at(1, 2); place_at(2, 1); place_at(2, 0); place_at(2, 2);
        check("draw_over", int'(bus.oGame_Over), 1);
        check("draw_winner", int'(bus.oWinner), 0);
        step(4'b0101, 1'b1);
        check("draw_clear_board", int'(bus.oBoard), 0);
        check("draw_clear_player", int'(bus.oPlayer), 1);
        check("draw_clear_x", int'(bus.oCursor_X), 70);
        check("draw_clear_y", int'(bus.oCursor_Y), 70);

        // reset landing in the CHECK cycle wins over the pending turn change
        do_reset();
        @(negedge clk);
        bus.iMOVE = 4'd0;
        bus.iPLACE = 1'b1;
        bus.iSTEP = 1'b0;
        n = 0;
        while (!dut.u_key.oPRESS && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("rst_pulse_seen", int'(n < 20), 1);
        @(negedge clk);
        rst = 1'b1;
        bus.iSTEP = 1'b1;
        @(negedge clk);
        model_reset();
        check_all("rst_in_check");
        check("rst_player", int'(bus.oPlayer), 1);
        rst = 1'b0;
        bus.iPLACE = 1'b0;
        repeat (10) @(negedge clk);
        check_all("after_rst");

        do_reset();
        repeat (80) step(4'($urandom_range(0, 15)), $urandom_range(0, 9) < 7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
